// File: rtl/dmem_port_arbiter.sv
// Arbitrates dmem port A between the CPU (priority) and a video burst reader with aging.
// Optional conflict counter: define ARB_PERF_CNT_EN to add the perf_conflicts port.

module dmem_port_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          reset,
  // CPU port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  // Video burst port
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_rvalid,
  output logic          vid_done,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]   perf_conflicts,
`endif
  // dmem port A
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(BURST_LEN - 1);
  localparam logic [WW-1:0] MaxWait  = WW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StCpu, StVburst} state_e;

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [WW-1:0] wait_cnt_q;
  logic          cpu_gnt_q;
  logic          cpu_rvalid_q;
  logic          vid_gnt_q;
  logic          vid_rvalid_q;
  logic          vid_done_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic          cpu_win;

  // CPU loses only when video has aged out.
  assign cpu_win = cpu_req && !(vid_req && (wait_cnt_q == MaxWait));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      wait_cnt_q   <= '0;
      cpu_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      vid_gnt_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      vid_done_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      vid_gnt_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      // Read data returns one cycle after the address was issued.
      cpu_rvalid_q <= (state_q == StCpu) && !mem_we_q;
      vid_rvalid_q <= vid_gnt_q;
      vid_done_q   <= vid_gnt_q && (beat_q == LastBeat);

      if (vid_req && (state_q != StVburst) && (wait_cnt_q != MaxWait)) begin
        wait_cnt_q <= wait_cnt_q + WW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (cpu_win) begin
            state_q     <= StCpu;
            cpu_gnt_q   <= 1'b1;
            mem_we_q    <= cpu_we;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
          end else if (vid_req) begin
            state_q    <= StVburst;
            vid_gnt_q  <= 1'b1;
            mem_addr_q <= vid_addr;
            beat_q     <= '0;
            wait_cnt_q <= '0;
          end
        end
        StCpu: begin
          state_q <= StIdle;
        end
        StVburst: begin
          if (beat_q == LastBeat) begin
            state_q <= StIdle;
          end else begin
            beat_q     <= beat_q + BW'(1);
            vid_gnt_q  <= 1'b1;
            mem_addr_q <= mem_addr_q + AW'(4);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
    end else if ((state_q == StIdle) && cpu_req && vid_req && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_conflicts = perf_q;
`endif

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
  assign vid_gnt    = vid_gnt_q;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rvalid_q ? mem_rdata : '0;
  assign vid_done   = vid_done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// transaction-queue reference model and a synchronous-read RAM.

module tb_dmem_port_arbiter;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned MAX_WAIT  = 8;
  localparam int K_IDLE = 0;
  localparam int K_CPU  = 1;
  localparam int K_VID  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt, vid_rvalid, vid_done;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]   perf_conflicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .AW(AW), .DW(DW), .BURST_LEN(BURST_LEN), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rdata(vid_rdata),
    .vid_rvalid(vid_rvalid), .vid_done(vid_done),
`ifdef ARB_PERF_CNT_EN
    .perf_conflicts(perf_conflicts),
`endif
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int idx);
    return 32'hA55A_0000 | 32'(idx * 7);
  endfunction

  // Synchronous-read RAM, 256 words aliased on addr[9:2].
  logic [31:0] ram [256];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else begin
      mem_rdata <= ram[mem_addr[9:2]];
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference model: queue of port actions the arbiter will drive, one per cycle.
  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        first;
    logic        last;
  } act_t;

  act_t        sched[$];
  act_t        cur;
  act_t        idle_act;
  logic [31:0] ref_mem [256];
  int          age;
  int          m_perf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    cur    = idle_act;
    age    = 0;
    m_perf = 0;
  endtask

  // Advance one clock with inputs as currently driven; check the next cycle.
  task automatic tick();
    act_t        a;
    logic        e_crv, e_vrv, e_done;
    logic [31:0] e_data;
    bit          vid_chosen;
    vid_chosen = 1'b0;
    if (cur.kind == K_IDLE) begin
      if (cpu_req && vid_req && m_perf < 65535) m_perf++;
      if (cpu_req && !(vid_req && age == MAX_WAIT)) begin
        a = '{kind: K_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata,
              first: 1'b1, last: 1'b1};
        sched.push_back(a);
      end else if (vid_req) begin
        for (int i = 0; i < BURST_LEN; i++) begin
          a = '{kind: K_VID, we: 1'b0, addr: vid_addr + 32'(4 * i), wdata: 32'h0,
                first: (i == 0), last: (i == BURST_LEN - 1)};
          sched.push_back(a);
        end
        vid_chosen = 1'b1;
      end
    end
    e_crv  = (cur.kind == K_CPU) && !cur.we;
    e_vrv  = (cur.kind == K_VID);
    e_done = e_vrv && cur.last;
    e_data = ref_mem[cur.addr[9:2]];
    if (cur.kind == K_CPU && cur.we) ref_mem[cur.addr[9:2]] = cur.wdata;
    if (vid_chosen) age = 0;
    else if (vid_req && cur.kind != K_VID && age < MAX_WAIT) age++;
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = idle_act;

    @(posedge clk);
    @(negedge clk);
    chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, cur.kind == K_CPU});
    chk("vid_gnt", {31'b0, vid_gnt}, {31'b0, cur.kind == K_VID});
    chk("mem_we", {31'b0, mem_we}, {31'b0, cur.kind == K_CPU && cur.we});
    chk("mem_addr", mem_addr, (cur.kind == K_IDLE) ? 32'h0 : cur.addr);
    chk("mem_wdata", mem_wdata, (cur.kind == K_CPU) ? cur.wdata : 32'h0);
    chk("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, e_crv});
    chk("vid_rvalid", {31'b0, vid_rvalid}, {31'b0, e_vrv});
    chk("vid_done", {31'b0, vid_done}, {31'b0, e_done});
    if (e_crv) chk("cpu_rdata", cpu_rdata, e_data);
    if (e_vrv) chk("vid_rdata", vid_rdata, e_data);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflicts", {16'b0, perf_conflicts}, 32'(m_perf));
`endif
  endtask

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = {22'b0, 8'($urandom), 2'b00};
    cpu_wdata = $urandom;
  endtask

  task automatic new_vid();
    vid_req  = 1'b1;
    vid_addr = {22'b0, 8'($urandom), 2'b00};
    if ($urandom_range(0, 7) == 0) vid_addr = vid_addr | 32'hFFFF_FC00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cpu_gnt"}, {31'b0, cpu_gnt}, 32'h0);
    chk({tag, "_cpu_rvalid"}, {31'b0, cpu_rvalid}, 32'h0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_vid_gnt"}, {31'b0, vid_gnt}, 32'h0);
    chk({tag, "_vid_rvalid"}, {31'b0, vid_rvalid}, 32'h0);
    chk({tag, "_vid_done"}, {31'b0, vid_done}, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    idle_act = '{kind: K_IDLE, we: 1'b0, addr: 32'h0, wdata: 32'h0, first: 1'b0, last: 1'b0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
`ifdef ARB_PERF_CNT_EN
    chk("reset_perf", {16'b0, perf_conflicts}, 32'h0);
`endif
    reset = 1'b1;
    tick();

    // CPU write then read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t1_wr_gnt", {31'b0, cpu_gnt}, 32'h1);
    cpu_we = 1'b0; cpu_wdata = 32'h0;
    tick();
    tick();
    chk("t1_rd_gnt", {31'b0, cpu_gnt}, 32'h1);
    cpu_req = 1'b0;
    tick();
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Video burst from 0x100
    vid_req = 1'b1; vid_addr = 32'h100;
    tick();
    chk("t2_beat0", mem_addr, 32'h100);
    vid_req = 1'b0;
    for (int i = 1; i < BURST_LEN; i++) begin
      tick();
      chk("t2_beat", mem_addr, 32'h100 + 32'(4 * i));
    end
    tick();
    chk("t2_done", {31'b0, vid_done}, 32'h1);
    tick();

    // Both requesters held high: aging eventually lets video through
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    vid_req = 1'b1; vid_addr = 32'h200;
    repeat (30) tick();
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (BURST_LEN + 2) tick();

    // CPU request arrives mid-burst and waits for the burst to finish
    vid_req = 1'b1; vid_addr = 32'h300;
    tick();
    vid_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1234_5678;
    repeat (3) tick();
    chk("t4_no_gnt", {31'b0, cpu_gnt}, 32'h0);
    tick();
    chk("t4_gnt", {31'b0, cpu_gnt}, 32'h1);
    cpu_req = 1'b0;
    repeat (2) tick();

    // Address wrap at the top of the address space
    vid_req = 1'b1; vid_addr = 32'hFFFF_FFF8;
    tick();
    vid_req = 1'b0;
    chk("t5_wrap0", mem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t5_wrap1", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t5_wrap2", mem_addr, 32'h0000_0000);
    tick();
    chk("t5_wrap3", mem_addr, 32'h0000_0004);
    repeat (3) tick();

    // Reset asserted on beat 2 aborts the burst
    vid_req = 1'b1; vid_addr = 32'hFFFF_FFF8;
    tick();
    vid_req = 1'b0;
    tick();
    tick();
    chk("t5_beat2_gnt", {31'b0, vid_gnt}, 32'h1);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_done", {31'b0, vid_done}, 32'h0);
      chk("midrst_rvalid", {31'b0, vid_rvalid}, 32'h0);
    end
    reset = 1'b1;
    repeat (2) tick();

    // Three idle cycles with both requests high
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    vid_req = 1'b1; vid_addr = 32'h340;
    repeat (4) tick();
    tick();
    cpu_req = 1'b0;
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf", {16'b0, perf_conflicts}, 32'h3);
`endif
    tick();
    vid_req = 1'b0;
    repeat (BURST_LEN + 2) tick();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if (!cpu_req && $urandom_range(0, 3) == 0) new_cpu();
      if (!vid_req && $urandom_range(0, 5) == 0) new_vid();
      tick();
      if (cur.kind == K_CPU) begin
        if ($urandom_range(0, 1) == 1) new_cpu();
        else cpu_req = 1'b0;
      end
      if (cur.kind == K_VID && cur.first) begin
        if ($urandom_range(0, 2) == 0) new_vid();
        else vid_req = 1'b0;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    repeat (BURST_LEN + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
